// File: rtl/pc_pipe_pkg.sv
// pc_pipe_pkg: shared CPU address width, vectors and stage index constants
package pc_pipe_pkg;
  localparam int CPU_ADDR_WIDTH = 32;
  localparam logic [CPU_ADDR_WIDTH-1:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [CPU_ADDR_WIDTH-1:0] DEF_EXC_VEC = 32'h0000_0080;
  typedef enum logic [2:0] {
    STG_FETCH  = 3'd0,
    STG_DECODE = 3'd1,
    STG_EXEC   = 3'd2,
    STG_MEM    = 3'd3,
    STG_WB     = 3'd4
  } stg_e;
endpackage

// File: rtl/pc_pipe_stage.sv
// pc_pipe_stage: one PC shadow register (pc, valid, bd when PC_PIPE_BD_TRACK_EN) with load/kill
module pc_pipe_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic              kill,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic              d_valid,
`ifdef PC_PIPE_BD_TRACK_EN
  input  logic              d_bd,
  output logic              bd,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      pc <= '0;
      valid <= 1'b0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      pc <= d_pc;
      valid <= d_valid;
    end
`ifdef PC_PIPE_BD_TRACK_EN
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) bd <= 1'b0;
    else if (load && !kill) bd <= d_bd;
`endif
endmodule

// File: rtl/pc_pipe.sv
// pc_pipe: PC generator and shadow pipeline with exception capture; PC_PIPE_BD_TRACK_EN adds delay-slot tracking
module pc_pipe
  import pc_pipe_pkg::*;
#(
  parameter int              ADDR_W    = CPU_ADDR_WIDTH,
  parameter int              STAGES    = 5,
  parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [ADDR_W-1:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int              STG_W     = 3
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     i_stall,
  input  logic                     i_j_valid,
  input  logic [ADDR_W-1:0]        i_j_addr,
  input  logic                     i_exc,
  input  logic [STG_W-1:0]         i_exc_stg,
  output logic [ADDR_W-1:0]        o_pc_next,
  output logic [STAGES*ADDR_W-1:0] o_pc,
  output logic [STAGES-1:0]        o_valid,
  output logic [ADDR_W-1:0]        o_epc,
  output logic                     o_bd,
  output logic                     o_exc_taken
);
  localparam int NS = 2**STG_W;
  logic [ADDR_W-1:0] pc_c [STAGES+1];
  logic [STAGES:0]   v_c;
  logic [ADDR_W-1:0] pc_x [NS];
  logic [NS-1:0]     v_x;
  logic              acc;
`ifdef PC_PIPE_BD_TRACK_EN
  logic [STAGES:0]   bd_c;
  logic [NS-1:0]     bd_x;
  assign bd_c[0] = i_j_valid;
`endif
  assign pc_c[0] = o_pc_next;
  assign v_c[0] = 1'b1;
  assign o_valid = v_c[STAGES:1];
  // out-of-range stage indices read as invalid, so they are ignored without a separate bound check
  assign v_x = NS'(v_c[STAGES:1]);
  assign acc = i_exc & v_x[i_exc_stg];
  genvar k;
  for (k = 0; k < NS; k++) begin : g_x
    if (k < STAGES) begin : g_s
      pc_pipe_stage #(.ADDR_W(ADDR_W)) u_stage (
        .clk     (clk),
        .nrst    (nrst),
        .load    (!i_stall),
        .kill    (acc && i_exc_stg >= STG_W'(k)),
        .d_pc    (pc_c[k]),
        .d_valid (v_c[k]),
`ifdef PC_PIPE_BD_TRACK_EN
        .d_bd    (bd_c[k]),
        .bd      (bd_c[k+1]),
`endif
        .pc      (pc_c[k+1]),
        .valid   (v_c[k+1])
      );
      assign pc_x[k] = pc_c[k+1];
      assign o_pc[k*ADDR_W +: ADDR_W] = pc_c[k+1];
`ifdef PC_PIPE_BD_TRACK_EN
      assign bd_x[k] = bd_c[k+1];
`endif
    end else begin : g_pad
      assign pc_x[k] = '0;
`ifdef PC_PIPE_BD_TRACK_EN
      assign bd_x[k] = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      o_pc_next <= RESET_VEC;
      o_epc <= '0;
      o_exc_taken <= 1'b0;
    end else begin
      o_pc_next <= acc ? EXC_VEC : i_stall ? o_pc_next : i_j_valid ? i_j_addr : o_pc_next + ADDR_W'(4);
      o_exc_taken <= acc;
`ifdef PC_PIPE_BD_TRACK_EN
      if (acc) o_epc <= bd_x[i_exc_stg] ? pc_x[i_exc_stg] - ADDR_W'(4) : pc_x[i_exc_stg];
`else
      if (acc) o_epc <= pc_x[i_exc_stg];
`endif
    end
`ifdef PC_PIPE_BD_TRACK_EN
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) o_bd <= 1'b0;
    else if (acc) o_bd <= bd_x[i_exc_stg];
`else
  assign o_bd = 1'b0;
`endif
endmodule

// File: tb/tb_pc_pipe.sv
// tb_pc_pipe: directed and random checks of pc_pipe against an array-based reference model
module tb_pc_pipe;
  localparam int NSTG = 5;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic i_stall = 1'b0;
  logic i_j_valid = 1'b0;
  logic [31:0] i_j_addr = '0;
  logic i_exc = 1'b0;
  logic [2:0] i_exc_stg = '0;
  logic [31:0] o_pc_next, o_epc, w_pc_next, w_epc;
  logic [NSTG*32-1:0] o_pc, w_pc;
  logic [NSTG-1:0] o_valid, w_valid;
  logic o_bd, o_exc_taken, w_bd, w_exc_taken;
  logic [31:0] m_next, m_epc;
  logic [31:0] m_pc [NSTG];
  bit m_v [NSTG];
  bit m_bd [NSTG];
  bit m_bdo, m_taken;
  int n_tot = 0;
  int n_pass = 0;
  pc_pipe dut (
    .clk(clk), .nrst(nrst), .i_stall(i_stall), .i_j_valid(i_j_valid), .i_j_addr(i_j_addr),
    .i_exc(i_exc), .i_exc_stg(i_exc_stg), .o_pc_next(o_pc_next), .o_pc(o_pc), .o_valid(o_valid),
    .o_epc(o_epc), .o_bd(o_bd), .o_exc_taken(o_exc_taken)
  );
  pc_pipe #(.RESET_VEC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .nrst(nrst), .i_stall(i_stall), .i_j_valid(i_j_valid), .i_j_addr(i_j_addr),
    .i_exc(i_exc), .i_exc_stg(i_exc_stg), .o_pc_next(w_pc_next), .o_pc(w_pc), .o_valid(w_valid),
    .o_epc(w_epc), .o_bd(w_bd), .o_exc_taken(w_exc_taken)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [31:0] m_valid();
    logic [31:0] r = '0;
    for (int k = 0; k < NSTG; k++) r[k] = m_v[k];
    return r;
  endfunction
  task automatic check_all();
    chk("pc_next", o_pc_next, m_next);
    for (int k = 0; k < NSTG; k++) chk($sformatf("stage%0d", k), o_pc[k*32 +: 32], m_pc[k]);
    chk("valid", 32'(o_valid), m_valid());
    chk("epc", o_epc, m_epc);
    chk("bd", 32'(o_bd), 32'(m_bdo));
    chk("exc_taken", 32'(o_exc_taken), 32'(m_taken));
  endtask
  task automatic model(input logic s, input logic jv, input logic [31:0] ja, input logic e, input logic [2:0] st);
    bit acc, fbd, bdon;
    logic [31:0] fpc;
`ifdef PC_PIPE_BD_TRACK_EN
    bdon = 1'b1;
`else
    bdon = 1'b0;
`endif
    acc = e && int'(st) < NSTG && m_v[int'(st) % NSTG];
    fpc = m_pc[int'(st) % NSTG];
    fbd = m_bd[int'(st) % NSTG];
    for (int k = NSTG - 1; k >= 0; k--)
      if (acc && k <= int'(st)) m_v[k] = 1'b0;
      else if (!s) begin
        m_pc[k] = (k == 0) ? m_next : m_pc[k-1];
        m_v[k] = (k == 0) ? 1'b1 : m_v[k-1];
        m_bd[k] = (k == 0) ? jv : m_bd[k-1];
      end
    if (acc) begin
      m_bdo = bdon && fbd;
      m_epc = m_bdo ? fpc - 32'd4 : fpc;
    end
    m_taken = acc;
    m_next = acc ? 32'h80 : s ? m_next : jv ? ja : m_next + 32'd4;
  endtask
  task automatic step(input logic s, input logic jv, input logic [31:0] ja, input logic e, input logic [2:0] st);
    i_stall = s;
    i_j_valid = jv;
    i_j_addr = ja;
    i_exc = e;
    i_exc_stg = st;
    @(posedge clk);
    model(s, jv, ja, e, st);
    #1;
    check_all();
  endtask
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 3'd0);
  endtask
  task automatic do_reset();
    i_stall = 1'b0;
    i_j_valid = 1'b0;
    i_exc = 1'b0;
    i_j_addr = '0;
    i_exc_stg = '0;
    nrst = 1'b0;
    #3;
    m_next = 32'h0;
    m_epc = 32'h0;
    m_bdo = 1'b0;
    m_taken = 1'b0;
    for (int k = 0; k < NSTG; k++) begin
      m_pc[k] = 32'h0;
      m_v[k] = 1'b0;
      m_bd[k] = 1'b0;
    end
    check_all();
    @(negedge clk);
    nrst = 1'b1;
  endtask
  initial begin
    do_reset();
    chk("wrap_reset", w_pc_next, 32'hFFFF_FFFC);
    adv(1);
    chk("wrap_adv", w_pc_next, 32'h0);
    adv(5);
    chk("plan_next", o_pc_next, 32'h18);
    for (int k = 0; k < NSTG; k++) chk($sformatf("plan_stage%0d", k), o_pc[k*32 +: 32], 32'h14 - 32'(4 * k));
    chk("plan_valid", 32'(o_valid), 32'h1F);
    do_reset();
    adv(4);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'h400, 1'b0, 3'd0);
      chk("stall_next", o_pc_next, 32'h10);
      chk("stall_stage0", o_pc[31:0], 32'h0C);
    end
    adv(1);
    chk("resume_next", o_pc_next, 32'h14);
    chk("resume_stage0", o_pc[31:0], 32'h10);
    do_reset();
    adv(3);
    step(1'b0, 1'b1, 32'h200, 1'b0, 3'd0);
    chk("jump_next", o_pc_next, 32'h200);
    chk("jump_slot", o_pc[31:0], 32'h0C);
    chk("jump_slot_valid", 32'(o_valid[0]), 32'h1);
    adv(1);
    chk("jump_target", o_pc[31:0], 32'h200);
    chk("jump_next2", o_pc_next, 32'h204);
    do_reset();
    adv(5);
    step(1'b1, 1'b0, 32'h0, 1'b1, 3'd2);
    chk("exc_next", o_pc_next, 32'h80);
    chk("exc_valid", 32'(o_valid), 32'h18);
    chk("exc_epc", o_epc, 32'h08);
    chk("exc_taken", 32'(o_exc_taken), 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 3'd0);
    chk("exc_pulse_end", 32'(o_exc_taken), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 3'd0);
    chk("exc_invalid_stage", 32'(o_exc_taken), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 3'd6);
    chk("exc_out_of_range", 32'(o_exc_taken), 32'h0);
    chk("exc_out_of_range_epc", o_epc, 32'h08);
    do_reset();
    adv(5);
    step(1'b0, 1'b1, 32'h300, 1'b1, 3'd1);
    chk("exc_jump_next", o_pc_next, 32'h80);
    chk("exc_jump_taken", 32'(o_exc_taken), 32'h1);
    do_reset();
    adv(4);
    step(1'b0, 1'b1, 32'h200, 1'b0, 3'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 3'd0);
`ifdef PC_PIPE_BD_TRACK_EN
    chk("bd_epc", o_epc, 32'h0C);
    chk("bd_flag", 32'(o_bd), 32'h1);
`else
    chk("bd_epc", o_epc, 32'h10);
    chk("bd_flag", 32'(o_bd), 32'h0);
`endif
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) do_reset();
      step(1'($urandom_range(3) == 0), 1'($urandom_range(6) == 0), {$urandom_range(32'hFFFF), 2'b00} + 32'h1000,
           1'($urandom_range(6) == 0), 3'($urandom_range(7)));
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/pc_pipe.md
Name: pc_pipe

Overview:
- Parametrised program-counter generator and PC shadow pipeline for the Ultiparc core.
- Generalises the fixed five-register PC chain to STAGES stages, each with a per-stage valid bit.
- Adds reset/exception vectors, jump redirect, pipeline flush and EPC capture.
- Sits beside the fetch/decode/execute stages in the CPU top and is driven by the core stall and redirect signals.

Parameters:
ADDR_W, 32, address width in bits
STAGES, 5, number of PC shadow stages after pc_next (2..8)
RESET_VEC, 32'h0000_0000, pc_next value after reset
EXC_VEC, 32'h0000_0080, pc_next value after a taken exception
STG_W, 3, width of the stage index (must satisfy 2**STG_W >= STAGES)

Ports:
clk  in  1  clock
nrst  in  1  reset
i_stall  in  1  core stall (fetch | exec | mem)
i_j_valid  in  1  jump/branch taken, from the execute stage
i_j_addr  in  ADDR_W  jump target
i_exc  in  1  exception request
i_exc_stg  in  STG_W  index of the stage raising the exception (0 = youngest)
o_pc_next  out  ADDR_W  address to fetch
o_pc  out  STAGES*ADDR_W  flattened stage PCs; stage k occupies bits [k*ADDR_W +: ADDR_W]
o_valid  out  STAGES  per-stage valid bits
o_epc  out  ADDR_W  captured exception PC
o_bd  out  1  excepting instruction was in a delay slot
o_exc_taken  out  1  one-cycle pulse on the cycle the exception is accepted

Behaviour:
- Reset is asynchronous, active-low, on nrst, with clock clk. Reset values:
  - o_pc_next = RESET_VEC
  - all o_pc = 0
  - o_valid = 0
  - o_epc = 0
  - o_bd = 0
  - o_exc_taken = 0
- Normal advance (i_stall=0, i_exc=0):
  - pc_next <= i_j_valid ? i_j_addr : pc_next+4. The addition wraps modulo 2^ADDR_W.
  - stage0 <= pc_next with valid0 <= 1.
  - stage k <= stage k-1 and valid k <= valid k-1.
- Stall (i_stall=1, i_exc=0): all registers hold. i_j_valid is ignored; execute re-presents it after the stall.
- Exception (i_exc=1) overrides stall and jump:
  - Accepted only if valid[i_exc_stg]=1; otherwise ignored entirely.
  - On acceptance:
    - pc_next <= EXC_VEC.
    - valid[0..i_exc_stg] <= 0.
    - Older stages (index > i_exc_stg) advance normally if i_stall=0 and hold if i_stall=1.
    - o_epc <= pc[i_exc_stg].
    - o_exc_taken pulses for one cycle.
  - i_exc_stg >= STAGES is ignored.
- Delay slot: the instruction following a taken jump stays valid (MIPS semantics). No flush on jump.
- Simultaneous i_exc and i_j_valid: the exception wins and the jump is dropped.
- No internal FSM beyond the registers. The pipeline is the state; o_exc_taken is a single-cycle flag register.
- Output latency: every output is registered, with one-cycle latency from inputs.

Optional Feature:
PC_PIPE_BD_TRACK_EN
- Defined:
  - Each stage carries a bd bit. stage0.bd <= i_j_valid at a non-stalled advance (the next fetched instruction is the delay slot).
  - On an accepted exception at a stage with bd=1: o_epc <= pc-4 and o_bd <= 1.
  - Otherwise: o_epc <= pc and o_bd <= 0.
- Undefined: no bd storage; o_bd is tied to 0 and o_epc is always the faulting PC.

Decomposition:
- Shared package/header (cpu_const.vh):
  - CPU_ADDR_WIDTH
  - default reset and exception vector constants
  - stage index constants: STG_FETCH=0, STG_DECODE=1, STG_EXEC=2, STG_MEM=3, STG_WB=4
- One natural sub-module: pc_pipe_stage, a single stage register (pc, valid, optional bd) with hold/load/kill controls, instantiated STAGES times in a generate loop.

Test Plan:
- Reset release, no stall, 6 cycles:
  - o_pc_next = 0x18.
  - stage0..4 = 0x14, 0x10, 0x0C, 0x08, 0x04.
  - o_valid = 5'b11111 after 5 cycles.
- i_stall=1 held 3 cycles at pc_next = 0x10: all outputs hold, then resume with 0x14.
- i_j_valid=1, i_j_addr=0x200 at pc_next = 0x0C:
  - next cycle pc_next = 0x200 and stage0 = 0x0C, valid (delay slot).
  - following cycle stage0 = 0x200.
- Exception at stage 2 holding 0x08 while i_stall=1:
  - pc_next = 0x80, valid[2:0] = 0, valid[4:3] unchanged.
  - o_epc = 0x08, o_exc_taken pulses once.
- Exception on an invalid stage, and simultaneous exception + jump:
  - invalid stage: no effect.
  - simultaneous case: pc_next = EXC_VEC, jump discarded.
- With PC_PIPE_BD_TRACK_EN: exception on the delay slot at 0x10 after a jump from 0x0C gives o_epc = 0x0C, o_bd = 1. Without the macro: o_epc = 0x10, o_bd = 0.
- Wrap: RESET_VEC = 0xFFFF_FFFC gives pc_next = 0x0000_0000 after one advance.
